// File: rtl/cosim_chg_packer_if.sv
// rtl/cosim_chg_packer_if.sv - DUT event inputs and record beat stream for cosim_chg_packer
interface cosim_chg_packer_if;
    logic        in_ready;
    logic        retire_valid;
    logic        retire_last;
    logic [1:0]  retire_prv;
    logic [63:0] retire_pc;
    logic [63:0] retire_ir;
    logic        op_valid;
    logic [7:0]  op_access;
    logic [63:0] op_addr;
    logic [63:0] op_data;
    logic        trap_valid;
    logic [1:0]  trap_prv;
    logic [7:0]  trap_cause;
    logic [63:0] trap_badaddr;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_kind;
    logic [4:0]  out_idx;
    logic [63:0] out_addr;
    logic [63:0] out_data;
    logic [15:0] out_aux;

    // Event source and record consumer side
    modport master (
        input  in_ready,
        output retire_valid, retire_last, retire_prv, retire_pc, retire_ir,
        output op_valid, op_access, op_addr, op_data,
        output trap_valid, trap_prv, trap_cause, trap_badaddr,
        input  out_valid, out_kind, out_idx, out_addr, out_data, out_aux,
        output out_ready
    );

    // Packer side
    modport slave (
        output in_ready,
        input  retire_valid, retire_last, retire_prv, retire_pc, retire_ir,
        input  op_valid, op_access, op_addr, op_data,
        input  trap_valid, trap_prv, trap_cause, trap_badaddr,
        output out_valid, out_kind, out_idx, out_addr, out_data, out_aux,
        input  out_ready
    );
endinterface

// File: rtl/cosim_chg_packer.sv
// rtl/cosim_chg_packer.sv - collects retire/op/trap events into a step record and drains it as beats
module cosim_chg_packer #(
    parameter int MAX_INSN = 4,
    parameter int MAX_OP   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    cosim_chg_packer_if.slave bus
);
    localparam int         IW       = (MAX_INSN > 1) ? $clog2(MAX_INSN) : 1;
    localparam int         OW       = (MAX_OP > 1) ? $clog2(MAX_OP) : 1;
    localparam logic [2:0] INSN_MAX = 3'(MAX_INSN);
    localparam logic [4:0] OP_MAX   = 5'(MAX_OP);

    typedef enum logic [1:0] {COLLECT, HDR, INSN, OP} state_t;

    state_t      state_q;
    logic [2:0]  icnt_q, icnt_d;
    logic [4:0]  ocnt_q, ocnt_d;
    logic        ovf_q, ovf_d;
    logic        trp_q, trp_d;
    logic [1:0]  tprv_q, tprv_d;
    logic [7:0]  tcause_q, tcause_d;
    logic [63:0] tbad_q, tbad_d;
    logic        close, ins_we, op_we;
    logic [63:0] hdr_data;

    logic [1:0]  ins_prv  [MAX_INSN];
    logic [63:0] ins_pc   [MAX_INSN];
    logic [63:0] ins_ir   [MAX_INSN];
    logic [7:0]  op_acc   [MAX_OP];
    logic [63:0] op_adr   [MAX_OP];
    logic [63:0] op_dat   [MAX_OP];
    logic [2:0]  op_inum  [MAX_OP];

    logic        out_valid_q;
    logic [1:0]  out_kind_q;
    logic [4:0]  out_idx_q;
    logic [63:0] out_addr_q, out_data_q;
    logic [15:0] out_aux_q;

    state_t      drn_state;
    logic [4:0]  drn_idx, nxt_idx;
    logic        drn_done;
    logic [1:0]  beat_kind;
    logic [63:0] beat_addr, beat_data;
    logic [15:0] beat_aux;

    assign bus.in_ready  = (state_q == COLLECT);
    assign bus.out_valid = out_valid_q;
    assign bus.out_kind  = out_kind_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_aux   = out_aux_q;

    // Accumulate this cycle's events and decide whether the step closes
    always_comb begin
        icnt_d   = icnt_q;
        ocnt_d   = ocnt_q;
        ovf_d    = ovf_q;
        trp_d    = trp_q;
        tprv_d   = tprv_q;
        tcause_d = tcause_q;
        tbad_d   = tbad_q;
        ins_we   = 1'b0;
        op_we    = 1'b0;
        close    = 1'b0;
        if (state_q == COLLECT) begin
            if (bus.retire_valid) begin
                ins_we = 1'b1;
                icnt_d = icnt_q + 3'd1;
            end
            if (bus.op_valid) begin
                if (ocnt_q == OP_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    op_we  = 1'b1;
                    ocnt_d = ocnt_q + 5'd1;
                end
            end
            if (bus.trap_valid) begin
                trp_d    = 1'b1;
                tprv_d   = bus.trap_prv;
                tcause_d = bus.trap_cause;
                tbad_d   = bus.trap_badaddr;
            end
            close = (bus.retire_valid && bus.retire_last) || bus.trap_valid
                    || (icnt_d == INSN_MAX);
        end
        hdr_data = {32'd0, tcause_d, 4'd0, tprv_d, ovf_d, trp_d, 3'd0, ocnt_d, 5'd0, icnt_d};
    end

    // Pick the beat that follows the current one; empty kinds are skipped
    always_comb begin
        nxt_idx   = out_idx_q + 5'd1;
        drn_state = COLLECT;
        drn_idx   = 5'd0;
        drn_done  = 1'b1;
        case (state_q)
            HDR: begin
                if (icnt_q != 3'd0) begin
                    drn_state = INSN;
                    drn_done  = 1'b0;
                end else if (ocnt_q != 5'd0) begin
                    drn_state = OP;
                    drn_done  = 1'b0;
                end
            end
            INSN: begin
                if (nxt_idx < {2'b00, icnt_q}) begin
                    drn_state = INSN;
                    drn_idx   = nxt_idx;
                    drn_done  = 1'b0;
                end else if (ocnt_q != 5'd0) begin
                    drn_state = OP;
                    drn_done  = 1'b0;
                end
            end
            OP: begin
                if (nxt_idx < ocnt_q) begin
                    drn_state = OP;
                    drn_idx   = nxt_idx;
                    drn_done  = 1'b0;
                end
            end
            default: ;
        endcase

        beat_kind = 2'd0;
        beat_addr = 64'd0;
        beat_data = 64'd0;
        beat_aux  = 16'd0;
        if (drn_state == INSN) begin
            beat_kind = 2'd1;
            beat_addr = ins_pc[drn_idx[IW-1:0]];
            beat_data = ins_ir[drn_idx[IW-1:0]];
            beat_aux  = {14'd0, ins_prv[drn_idx[IW-1:0]]};
        end else if (drn_state == OP) begin
            beat_kind = 2'd2;
            beat_addr = op_adr[drn_idx[OW-1:0]];
            beat_data = op_dat[drn_idx[OW-1:0]];
            beat_aux  = {5'd0, op_inum[drn_idx[OW-1:0]], op_acc[drn_idx[OW-1:0]]};
        end
    end

    // Record slot storage; contents are only meaningful below icnt/ocnt
    always_ff @(posedge clk) begin
        if (ins_we) begin
            ins_prv[icnt_q[IW-1:0]] <= bus.retire_prv;
            ins_pc[icnt_q[IW-1:0]]  <= bus.retire_pc;
            ins_ir[icnt_q[IW-1:0]]  <= bus.retire_ir;
        end
        if (op_we) begin
            op_acc[ocnt_q[OW-1:0]]  <= bus.op_access;
            op_adr[ocnt_q[OW-1:0]]  <= bus.op_addr;
            op_dat[ocnt_q[OW-1:0]]  <= bus.op_data;
            op_inum[ocnt_q[OW-1:0]] <= icnt_q;
        end
    end

    // Step FSM: collect, then present header/instruction/op beats with registered payload
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            icnt_q      <= 3'd0;
            ocnt_q      <= 5'd0;
            ovf_q       <= 1'b0;
            trp_q       <= 1'b0;
            tprv_q      <= 2'd0;
            tcause_q    <= 8'd0;
            tbad_q      <= 64'd0;
            out_valid_q <= 1'b0;
            out_kind_q  <= 2'd0;
            out_idx_q   <= 5'd0;
            out_addr_q  <= 64'd0;
            out_data_q  <= 64'd0;
            out_aux_q   <= 16'd0;
        end else begin
            case (state_q)
                COLLECT: begin
                    icnt_q   <= icnt_d;
                    ocnt_q   <= ocnt_d;
                    ovf_q    <= ovf_d;
                    trp_q    <= trp_d;
                    tprv_q   <= tprv_d;
                    tcause_q <= tcause_d;
                    tbad_q   <= tbad_d;
                    if (close) begin
                        state_q     <= HDR;
                        out_valid_q <= 1'b1;
                        out_kind_q  <= 2'd0;
                        out_idx_q   <= 5'd0;
                        out_addr_q  <= tbad_d;
                        out_data_q  <= hdr_data;
                        out_aux_q   <= 16'd0;
                    end
                end
                default: begin
                    if (out_valid_q && bus.out_ready) begin
                        if (drn_done) begin
                            state_q     <= COLLECT;
                            icnt_q      <= 3'd0;
                            ocnt_q      <= 5'd0;
                            ovf_q       <= 1'b0;
                            trp_q       <= 1'b0;
                            tprv_q      <= 2'd0;
                            tcause_q    <= 8'd0;
                            tbad_q      <= 64'd0;
                            out_valid_q <= 1'b0;
                            out_kind_q  <= 2'd0;
                            out_idx_q   <= 5'd0;
                            out_addr_q  <= 64'd0;
                            out_data_q  <= 64'd0;
                            out_aux_q   <= 16'd0;
                        end else begin
                            state_q    <= drn_state;
                            out_kind_q <= beat_kind;
                            out_idx_q  <= drn_idx;
                            out_addr_q <= beat_addr;
                            out_data_q <= beat_data;
                            out_aux_q  <= beat_aux;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cosim_chg_packer.sv
// tb/tb_cosim_chg_packer.sv - directed vector bench for cosim_chg_packer
module tb_cosim_chg_packer;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

    cosim_chg_packer_if bus();

    cosim_chg_packer #(.MAX_INSN(4), .MAX_OP(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic        rl;
        logic [1:0]  rprv;
        logic [63:0] pc;
        logic [63:0] ir;
        logic        ov;
        logic [7:0]  acc;
        logic [63:0] oaddr;
        logic [63:0] odata;
        logic        tv;
        logic [1:0]  tprv;
        logic [7:0]  cause;
        logic [63:0] bad_addr;
        logic [63:0] hdr;
        int          ni;
        int          no;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_ev();
        bus.retire_valid = 1'b0;
        bus.retire_last  = 1'b0;
        bus.op_valid     = 1'b0;
        bus.trap_valid   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_ev();
    endtask

    task automatic set_retire(input logic last, input logic [1:0] prv, input logic [63:0] pc, input logic [63:0] ir);
        bus.retire_valid = 1'b1;
        bus.retire_last  = last;
        bus.retire_prv   = prv;
        bus.retire_pc    = pc;
        bus.retire_ir    = ir;
    endtask

    task automatic set_op(input logic [7:0] acc, input logic [63:0] a, input logic [63:0] d);
        bus.op_valid  = 1'b1;
        bus.op_access = acc;
        bus.op_addr   = a;
        bus.op_data   = d;
    endtask

    task automatic set_trap(input logic [1:0] prv, input logic [7:0] cause, input logic [63:0] ba);
        bus.trap_valid   = 1'b1;
        bus.trap_prv     = prv;
        bus.trap_cause   = cause;
        bus.trap_badaddr = ba;
    endtask

    task automatic expect_beat(input string nm, input logic [1:0] k, input logic [4:0] i,
                               input logic [63:0] a, input logic [63:0] d, input logic [15:0] x);
        logic got;
        logic [1:0]  gk;
        logic [4:0]  gi;
        logic [63:0] ga, gd;
        logic [15:0] gx;
        got = 1'b0;
        gk = '0; gi = '0; ga = '0; gd = '0; gx = '0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                got = 1'b1;
                gk = bus.out_kind; gi = bus.out_idx; ga = bus.out_addr;
                gd = bus.out_data; gx = bus.out_aux;
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b0;
        chk({nm, " present"}, 64'(got), 64'd1);
        chk({nm, " kind"}, 64'(gk), 64'(k));
        chk({nm, " idx"}, 64'(gi), 64'(i));
        chk({nm, " addr"}, ga, a);
        chk({nm, " data"}, gd, d);
        chk({nm, " aux"}, 64'(gx), 64'(x));
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({nm, " out_valid"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b1, 2'd3, 64'h1000, 64'h13, 1'b0, 8'd0, 64'd0, 64'd0,
                  1'b0, 2'd0, 8'd0, 64'd0, 64'h0000_0001, 1, 0};
        vt[1] = '{1'b1, 1'b1, 2'd1, 64'h3000, 64'h6f, 1'b1, 8'd17, 64'd7, 64'hAA,
                  1'b0, 2'd0, 8'd0, 64'd0, 64'h0000_0101, 1, 1};
        vt[2] = '{1'b0, 1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 8'd0, 64'd0, 64'd0,
                  1'b1, 2'd1, 8'd5, 64'h40, 64'h0505_0000, 0, 0};
        vt[3] = '{1'b1, 1'b0, 2'd0, 64'h2000, 64'h73, 1'b0, 8'd0, 64'd0, 64'd0,
                  1'b1, 2'd3, 8'd8, 64'd0, 64'h080D_0001, 1, 0};
        vt[4] = '{1'b0, 1'b0, 2'd0, 64'd0, 64'd0, 1'b1, 8'd2, 64'd3, 64'd9,
                  1'b1, 2'd0, 8'd0, 64'h11, 64'h0001_0100, 0, 1};

        rst_n = 1'b0;
        clear_ev();
        bus.retire_prv = '0; bus.retire_pc = '0; bus.retire_ir = '0;
        bus.op_access = '0; bus.op_addr = '0; bus.op_data = '0;
        bus.trap_prv = '0; bus.trap_cause = '0; bus.trap_badaddr = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst out_kind", 64'(bus.out_kind), 64'd0);
        chk("rst out_idx", 64'(bus.out_idx), 64'd0);
        chk("rst out_addr", bus.out_addr, 64'd0);
        chk("rst out_data", bus.out_data, 64'd0);
        chk("rst out_aux", 64'(bus.out_aux), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("post-rst");

        // Single-cycle steps from the vector table
        for (int v = 0; v < 5; v++) begin
            if (vt[v].rv) set_retire(vt[v].rl, vt[v].rprv, vt[v].pc, vt[v].ir);
            if (vt[v].ov) set_op(vt[v].acc, vt[v].oaddr, vt[v].odata);
            if (vt[v].tv) set_trap(vt[v].tprv, vt[v].cause, vt[v].bad_addr);
            tick();
            chk($sformatf("v%0d latency out_valid", v), 64'(bus.out_valid), 64'd1);
            chk($sformatf("v%0d in_ready low", v), 64'(bus.in_ready), 64'd0);
            expect_beat($sformatf("v%0d hdr", v), 2'd0, 5'd0, vt[v].bad_addr, vt[v].hdr, 16'd0);
            if (vt[v].ni > 0)
                expect_beat($sformatf("v%0d insn", v), 2'd1, 5'd0, vt[v].pc, vt[v].ir, {14'd0, vt[v].rprv});
            if (vt[v].no > 0)
                expect_beat($sformatf("v%0d op", v), 2'd2, 5'd0, vt[v].oaddr, vt[v].odata, {8'd0, vt[v].acc});
            chk_idle($sformatf("v%0d done", v));
        end

        // Two retires, op attributed to the first
        set_retire(1'b0, 2'd3, 64'h8000_0000, 64'h0050_0293);
        set_op(8'd1, 64'd5, 64'h1234);
        tick();
        chk("two-ret mid in_ready", 64'(bus.in_ready), 64'd1);
        set_retire(1'b1, 2'd3, 64'h8000_0004, 64'h0000_0013);
        tick();
        expect_beat("two-ret hdr", 2'd0, 5'd0, 64'd0, 64'h0102, 16'd0);
        expect_beat("two-ret insn0", 2'd1, 5'd0, 64'h8000_0000, 64'h0050_0293, 16'd3);
        expect_beat("two-ret insn1", 2'd1, 5'd1, 64'h8000_0004, 64'h0000_0013, 16'd3);
        expect_beat("two-ret op0", 2'd2, 5'd0, 64'd5, 64'h1234, 16'h0001);
        chk_idle("two-ret done");

        // Trap alone
        set_trap(2'd3, 8'd2, 64'hDEAD);
        tick();
        expect_beat("trap hdr", 2'd0, 5'd0, 64'hDEAD, 64'h020D_0000, 16'd0);
        chk_idle("trap done");

        // 17 ops overflow the op table
        for (int i = 0; i < 17; i++) begin
            set_op(8'd3, 64'(i), 64'h100 + 64'(i));
            tick();
        end
        chk_idle("ovf collecting");
        set_retire(1'b1, 2'd0, 64'h8000, 64'h1);
        tick();
        expect_beat("ovf hdr", 2'd0, 5'd0, 64'd0, 64'h0002_1001, 16'd0);
        expect_beat("ovf insn0", 2'd1, 5'd0, 64'h8000, 64'h1, 16'd0);
        for (int j = 0; j < 16; j++)
            expect_beat($sformatf("ovf op%0d", j), 2'd2, 5'(j), 64'(j), 64'h100 + 64'(j), 16'h0003);
        chk_idle("ovf done");

        // Four retires without retire_last close at MAX_INSN
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk_idle("four-ret before 4th");
            set_retire(1'b0, 2'd0, 64'h9000 + 64'(4 * i), 64'(i + 10));
            tick();
        end
        chk("four-ret latency", 64'(bus.out_valid), 64'd1);
        expect_beat("four-ret hdr", 2'd0, 5'd0, 64'd0, 64'h0004, 16'd0);
        for (int i = 0; i < 4; i++)
            expect_beat($sformatf("four-ret insn%0d", i), 2'd1, 5'(i), 64'h9000 + 64'(4 * i), 64'(i + 10), 16'd0);
        chk_idle("four-ret done");

        // Backpressure on insn beat 0; events offered meanwhile must be ignored
        set_retire(1'b1, 2'd2, 64'h5000, 64'h99);
        tick();
        expect_beat("stall hdr", 2'd0, 5'd0, 64'd0, 64'h0001, 16'd0);
        set_retire(1'b1, 2'd1, 64'hBAD, 64'hBAD);
        set_trap(2'd1, 8'd9, 64'hBAD);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d out_valid", c), 64'(bus.out_valid), 64'd1);
            chk($sformatf("stall%0d addr", c), bus.out_addr, 64'h5000);
            chk($sformatf("stall%0d kind", c), 64'(bus.out_kind), 64'd1);
            chk($sformatf("stall%0d in_ready", c), 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        clear_ev();
        expect_beat("stall insn0", 2'd1, 5'd0, 64'h5000, 64'h99, 16'd2);
        chk_idle("stall done");
        set_trap(2'd0, 8'd1, 64'h7);
        tick();
        expect_beat("post-stall hdr", 2'd0, 5'd0, 64'h7, 64'h0101_0000, 16'd0);
        chk_idle("post-stall done");

        // Reset during op beat 3
        for (int i = 0; i < 5; i++) begin
            set_op(8'd4, 64'h100 + 64'(i), 64'(i));
            tick();
        end
        set_retire(1'b1, 2'd0, 64'h6000, 64'h5);
        tick();
        expect_beat("rst-drain hdr", 2'd0, 5'd0, 64'd0, 64'h0501, 16'd0);
        expect_beat("rst-drain insn0", 2'd1, 5'd0, 64'h6000, 64'h5, 16'd0);
        for (int j = 0; j < 3; j++)
            expect_beat($sformatf("rst-drain op%0d", j), 2'd2, 5'(j), 64'h100 + 64'(j), 64'(j), 16'h0004);
        @(negedge clk);
        chk("rst-drain op3 idx", 64'(bus.out_idx), 64'd3);
        chk("rst-drain op3 kind", 64'(bus.out_kind), 64'd2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst-drain out_valid", 64'(bus.out_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("rst-drain released");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst-drain quiet%0d", c), 64'(bus.out_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b0;
        set_retire(1'b1, 2'd1, 64'h7000, 64'h77);
        tick();
        expect_beat("fresh hdr", 2'd0, 5'd0, 64'd0, 64'h0001, 16'd0);
        expect_beat("fresh insn0", 2'd1, 5'd0, 64'h7000, 64'h77, 16'd1);
        chk_idle("fresh done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
